// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Segment codes are active-low and packed {g,f,e,d,c,b,a}.
// Digit indices select the units or tens position of a two-digit display.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {
    DIG_UNITS = 1'b0,
    DIG_TENS  = 1'b1
  } digit_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Values 10..15 are not BCD and show a dash (segment g only).
// Ports:
//   bcd   - 4-bit input nibble
//   seg_n - segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed common-anode 7-segment scanner for a packed BCD count.
// The count is snapshotted once per frame (at the start of the units slot),
// each slot opens with dead time to avoid ghosting, the tens digit may be
// blanked when zero, and the whole display can blink at a frame-based rate.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high
//   bcd_in      - {tens, units} packed BCD
//   blank_lz    - blank a zero tens digit
//   blink_en    - darken the display during the blink off-phase
//   seg_n       - segments {g,f,e,d,c,b,a}, active-low
//   dig_sel_n   - [0] units, [1] tens; active-low digit enables
//   frame_start - one-cycle pulse on the first output cycle of each frame
//   err         - sticky: a non-BCD nibble was captured
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 8,
  parameter int DEAD_CYCLES  = 1,
  parameter int BLINK_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bcd_in,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [6:0] seg_n,
  output logic [1:0] dig_sel_n,
  output logic       frame_start,
  output logic       err
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_END = DIV_W'(DEAD_CYCLES);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  function automatic logic nibble_bad(input logic [3:0] n);
    return n > 4'd9;
  endfunction

  // Stage p0: slot state (scan counters, snapshot, blink phase)
  logic [DIV_W-1:0] div_cnt_p0;
  digit_e           digit_p0;
  logic [7:0]       snapshot_p0;
  logic [FRM_W-1:0] frame_cnt_p0;
  logic             blink_off_p0;

  logic       boundary_p0;
  logic       slot_end_p0;
  logic       frame_end_p0;
  logic [7:0] snap_next_p0;
  logic [3:0] nibble_p0;
  logic [6:0] dec_seg_p0;
  logic       dark_p0;
  logic       bad_in_p0;

  assign boundary_p0  = (div_cnt_p0 == '0) && (digit_p0 == DIG_UNITS);
  assign slot_end_p0  = (div_cnt_p0 == DIV_LAST);
  assign frame_end_p0 = slot_end_p0 && (digit_p0 == DIG_TENS);

  // On a boundary the value being captured is shown straight away, so the
  // first units slot of a frame never displays the previous frame's count.
  assign snap_next_p0 = boundary_p0 ? bcd_in : snapshot_p0;
  assign nibble_p0    = (digit_p0 == DIG_TENS) ? snap_next_p0[7:4] : snap_next_p0[3:0];
  assign bad_in_p0    = nibble_bad(bcd_in[7:4]) || nibble_bad(bcd_in[3:0]);

  // Leading-zero blanking and blink off-phase both reuse the dead-time path.
  assign dark_p0 = (div_cnt_p0 < DEAD_END)
                || (blank_lz && (digit_p0 == DIG_TENS) && (snap_next_p0[7:4] == 4'd0))
                || (blink_en && blink_off_p0);

  bcd_to_seg7 u_dec (
    .bcd   (nibble_p0),
    .seg_n (dec_seg_p0)
  );

  // Stage p1: registered display outputs
  logic [6:0] seg_n_p1;
  logic [1:0] dig_sel_n_p1;
  logic       frame_start_p1;
  logic       err_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_p0     <= '0;
      digit_p0       <= DIG_UNITS;
      snapshot_p0    <= 8'h00;
      frame_cnt_p0   <= '0;
      blink_off_p0   <= 1'b0;
      seg_n_p1       <= SEG_BLANK;
      dig_sel_n_p1   <= 2'b11;
      frame_start_p1 <= 1'b0;
      err_p1         <= 1'b0;
    end else begin
      if (slot_end_p0) begin
        div_cnt_p0 <= '0;
        digit_p0   <= (digit_p0 == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
      end else begin
        div_cnt_p0 <= div_cnt_p0 + DIV_W'(1);
      end

      if (boundary_p0) begin
        snapshot_p0 <= bcd_in;
      end

      if (frame_end_p0) begin
        if (frame_cnt_p0 == FRM_LAST) begin
          frame_cnt_p0 <= '0;
          blink_off_p0 <= ~blink_off_p0;
        end else begin
          frame_cnt_p0 <= frame_cnt_p0 + FRM_W'(1);
        end
      end

      seg_n_p1       <= dark_p0 ? SEG_BLANK : dec_seg_p0;
      dig_sel_n_p1   <= dark_p0 ? 2'b11 : ((digit_p0 == DIG_TENS) ? 2'b01 : 2'b10);
      frame_start_p1 <= boundary_p0;
      err_p1         <= err_p1 || (boundary_p0 && bad_in_p0);
    end
  end

  assign seg_n       = seg_n_p1;
  assign dig_sel_n   = dig_sel_n_p1;
  assign frame_start = frame_start_p1;
  assign err         = err_p1;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner with SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2.
module tb_bcd_display_scanner;

  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BF = 2;
  localparam int FP = 2 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bcd_in;
  logic       blank_lz;
  logic       blink_en;
  logic [6:0] seg_n;
  logic [1:0] dig_sel_n;
  logic       frame_start;
  logic       err;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .SCAN_DIV     (SD),
    .DEAD_CYCLES  (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bcd_in      (bcd_in),
    .blank_lz    (blank_lz),
    .blink_en    (blink_en),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .frame_start (frame_start),
    .err         (err)
  );

  typedef struct {
    logic [6:0] seg;
    logic [1:0] dig;
    logic       fs;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] bcd;
    logic       blz;
    logic [6:0] u_seg;
    logic [6:0] t_seg;
    logic [1:0] t_dig;
    logic       err;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[10];
  int         total = 0;
  int         bad = 0;
  int         t = 0;
  logic [7:0] snap_m = 8'h00;
  logic       err_m = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0d: got %h want %h", name, t, act, want);
    end
  endtask

  // Advance one clock and compare the DUT outputs with the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty t=%0d", t);
    end else begin
      e = sb.pop_front();
      chk("seg_n", seg_n, e.seg);
      chk("dig_sel_n", 7'(dig_sel_n), 7'(e.dig));
      chk("frame_start", 7'(frame_start), 7'(e.fs));
      chk("err", 7'(err), 7'(e.err));
    end
    t = reset ? 0 : t + 1;
  endtask

  // Reference: t counts cycles since reset released; frame f = t / FP.
  task automatic model_push();
    exp_t e;
    int   pos;
    int   f;
    logic tens;
    logic dark;
    if (reset) begin
      e = '{7'h7F, 2'b11, 1'b0, 1'b0};
      err_m = 1'b0;
    end else begin
      pos = t % FP;
      f   = t / FP;
      if (pos == 0) begin
        snap_m = bcd_in;
        if (snap_m[7:4] > 4'd9 || snap_m[3:0] > 4'd9) err_m = 1'b1;
      end
      tens = (pos >= SD);
      dark = ((pos % SD) < DC)
          || (blink_en && ((f / BF) % 2 == 1))
          || (blank_lz && tens && snap_m[7:4] == 4'd0);
      if (dark) begin
        e.seg = 7'h7F;
        e.dig = 2'b11;
      end else begin
        e.seg = ref_seg(tens ? snap_m[7:4] : snap_m[3:0]);
        e.dig = tens ? 2'b01 : 2'b10;
      end
      e.fs  = (pos == 0);
      e.err = err_m;
    end
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      model_push();
      tick();
    end
  endtask

  initial begin
    exp_t e;

    vecs[0] = '{8'h37, 1'b0, 7'h78, 7'h30, 2'b01, 1'b0};
    vecs[1] = '{8'h52, 1'b0, 7'h24, 7'h12, 2'b01, 1'b0};
    vecs[2] = '{8'h05, 1'b1, 7'h12, 7'h7F, 2'b11, 1'b0};
    vecs[3] = '{8'h05, 1'b0, 7'h12, 7'h40, 2'b01, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 7'h40, 7'h7F, 2'b11, 1'b0};
    vecs[5] = '{8'h99, 1'b0, 7'h10, 7'h10, 2'b01, 1'b0};
    vecs[6] = '{8'h86, 1'b1, 7'h02, 7'h00, 2'b01, 1'b0};
    vecs[7] = '{8'h14, 1'b0, 7'h19, 7'h79, 2'b01, 1'b0};
    vecs[8] = '{8'h3C, 1'b0, 7'h3F, 7'h30, 2'b01, 1'b1};
    vecs[9] = '{8'h12, 1'b0, 7'h24, 7'h79, 2'b01, 1'b1};

    reset    = 1'b1;
    bcd_in   = 8'h37;
    blank_lz = 1'b0;
    blink_en = 1'b0;

    // Reset held three cycles: outputs dark, no pulse, no error.
    run(3);
    reset = 1'b0;

    // Table: one whole frame per vector, inputs applied at the boundary.
    for (int i = 0; i < 10; i++) begin
      bcd_in   = vecs[i].bcd;
      blank_lz = vecs[i].blz;
      for (int p = 0; p < FP; p++) begin
        if ((p % SD) < DC) begin
          e.seg = 7'h7F;
          e.dig = 2'b11;
        end else if (p < SD) begin
          e.seg = vecs[i].u_seg;
          e.dig = 2'b10;
        end else begin
          e.seg = vecs[i].t_seg;
          e.dig = vecs[i].t_dig;
        end
        e.fs  = (p == 0);
        e.err = vecs[i].err;
        sb.push_back(e);
        tick();
      end
    end

    // Snapshot stability: a mid-frame change waits for the next frame.
    reset    = 1'b1;
    bcd_in   = 8'h37;
    blank_lz = 1'b0;
    run(2);
    reset = 1'b0;
    run(FP + 3);
    bcd_in = 8'h52;
    run(5 + FP);

    // Reset mid-frame restarts the scan and discards the snapshot.
    run(3);
    reset = 1'b1;
    run(1);
    reset    = 1'b0;
    bcd_in   = 8'h05;
    blank_lz = 1'b1;
    run(FP);
    blank_lz = 1'b0;
    run(FP);
    // blank_lz toggled mid-slot acts immediately.
    run(SD + 2);
    blank_lz = 1'b1;
    run(SD - 2);

    // Sticky error survives valid input until reset.
    blank_lz = 1'b0;
    bcd_in   = 8'h3C;
    run(FP);
    bcd_in = 8'h12;
    run(2 * FP);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(FP);

    // Blink: two lit frames, two dark frames, repeating; pulse continues.
    bcd_in = 8'h37;
    reset  = 1'b1;
    run(1);
    reset    = 1'b0;
    blink_en = 1'b1;
    run(5 * FP);
    blink_en = 1'b0;
    run(FP / 2);
    blink_en = 1'b1;
    run(FP + FP / 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
